// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: snapshots a packed digit word once per frame and
// time-multiplexes decoded digits onto a shared segment bus with one-hot commons.
module seg_scan_driver #(
    parameter int unsigned DIGITS         = 6,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter bit          COM_ACTIVE_LOW = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   BCD_IN,
    input  logic [DIGITS-1:0]     DOT_IN,
    input  logic                  HEX_MODE,
    input  logic                  BLANK_LZ,
    output logic [7:0]            SEG_DATA,
    output logic [DIGITS-1:0]     SEG_COM,
    output logic                  FRAME_TICK
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] COM_OFF  = COM_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PRE_W-1:0]    r_pre;
    logic [IDX_W-1:0]    r_idx;
    logic                r_first;
    logic [4*DIGITS-1:0] r_snap_val;
    logic [DIGITS-1:0]   r_snap_dot;
    logic                r_snap_hex;
    logic                r_snap_blz;

    logic                w_pre_wrap;
    logic                w_load;
    logic [3:0]          w_digit;
    logic                w_dot;
    logic                w_blank_sel;
    logic                w_lead;
    logic [DIGITS-1:0]   w_blank;
    logic [DIGITS-1:0]   w_onehot;
    logic [DIGITS-1:0]   w_com_on;
    logic [6:0]          w_seg7;
    logic [7:0]          w_seg;

    assign w_pre_wrap = (r_pre == PRE_LAST);
    assign w_load     = r_first | (w_pre_wrap & (r_idx == IDX_LAST));

    // Leading-zero mask: stays set from the top digit down until a nonzero or dotted digit
    always_comb begin
        w_lead  = 1'b1;
        w_blank = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if ((r_snap_val[4*i +: 4] != 4'h0) || r_snap_dot[i]) begin
                w_lead = 1'b0;
            end
            w_blank[i] = r_snap_blz & w_lead & (i != 0);
        end
    end

    always_comb begin
        w_digit     = 4'h0;
        w_dot       = 1'b0;
        w_blank_sel = 1'b0;
        w_onehot    = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit     = r_snap_val[4*i +: 4];
                w_dot       = r_snap_dot[i];
                w_blank_sel = w_blank[i];
                w_onehot[i] = 1'b1;
            end
        end
        w_com_on = COM_ACTIVE_LOW ? ~w_onehot : w_onehot;
    end

    // Segment decode, bit order {a,b,c,d,e,f,g}
    always_comb begin
        w_seg7 = 7'b0000000;
        case (w_digit)
            4'h0: w_seg7 = 7'b1111110;
            4'h1: w_seg7 = 7'b0110000;
            4'h2: w_seg7 = 7'b1101101;
            4'h3: w_seg7 = 7'b1111001;
            4'h4: w_seg7 = 7'b0110011;
            4'h5: w_seg7 = 7'b1011011;
            4'h6: w_seg7 = 7'b1011111;
            4'h7: w_seg7 = 7'b1110000;
            4'h8: w_seg7 = 7'b1111111;
            4'h9: w_seg7 = 7'b1111011;
            4'hA: w_seg7 = r_snap_hex ? 7'b1110111 : 7'b0000000;
            4'hB: w_seg7 = r_snap_hex ? 7'b0011111 : 7'b0000000;
            4'hC: w_seg7 = r_snap_hex ? 7'b1001110 : 7'b0000000;
            4'hD: w_seg7 = r_snap_hex ? 7'b0111101 : 7'b0000000;
            4'hE: w_seg7 = r_snap_hex ? 7'b1001111 : 7'b0000000;
            default: w_seg7 = r_snap_hex ? 7'b1000111 : 7'b0000000;
        endcase
        if (w_blank_sel) begin
            w_seg7 = 7'b0000000;
        end
        w_seg = {w_seg7, w_dot};
    end

    // Scan counters, frame snapshot and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pre      <= '0;
            r_idx      <= '0;
            r_first    <= 1'b1;
            r_snap_val <= '0;
            r_snap_dot <= '0;
            r_snap_hex <= 1'b0;
            r_snap_blz <= 1'b0;
            SEG_DATA   <= 8'h00;
            SEG_COM    <= COM_OFF;
            FRAME_TICK <= 1'b0;
        end else begin
            r_pre <= w_pre_wrap ? '0 : r_pre + PRE_W'(1);
            if (w_pre_wrap) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end
            if (w_load) begin
                r_snap_val <= BCD_IN;
                r_snap_dot <= DOT_IN;
                r_snap_hex <= HEX_MODE;
                r_snap_blz <= BLANK_LZ;
            end
            r_first    <= 1'b0;
            FRAME_TICK <= w_load;
            SEG_DATA   <= w_seg;
            SEG_COM    <= (r_pre == '0) ? COM_OFF : w_com_on;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a frame-level reference model predicts every
// output cycle; scenario tasks add fixed-pattern spot checks.
module tb_seg_scan_driver;

    localparam int D = 4;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd;
    logic [3:0]  dot;
    logic        hex, blz;
    logic [7:0]  seg;
    logic [3:0]  com;
    logic        tick;

    logic        rst1;
    logic [3:0]  bcd1;
    logic        dot1;
    logic [7:0]  seg1;
    logic        com1;
    logic        tick1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          k;
    logic [15:0] m_val;
    logic [3:0]  m_dot;
    logic        m_hex, m_blz;
    logic [7:0]  e_seg;
    logic [3:0]  e_com;
    logic        e_tick;
    logic [6:0]  seg_tab [16];

    always #5 clk = ~clk;

    seg_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .COM_ACTIVE_LOW(1'b1)) dut (
        .CLK(clk), .RST(rst), .BCD_IN(bcd), .DOT_IN(dot), .HEX_MODE(hex),
        .BLANK_LZ(blz), .SEG_DATA(seg), .SEG_COM(com), .FRAME_TICK(tick)
    );

    seg_scan_driver #(.DIGITS(1), .SCAN_DIV(3), .COM_ACTIVE_LOW(1'b0)) dut1 (
        .CLK(clk), .RST(rst1), .BCD_IN(bcd1), .DOT_IN(dot1), .HEX_MODE(1'b0),
        .BLANK_LZ(1'b0), .SEG_DATA(seg1), .SEG_COM(com1), .FRAME_TICK(tick1)
    );

    // Digit i of the current model snapshot, including leading-zero suppression
    function automatic logic [7:0] m_decode(input int i);
        int         v;
        int         msd;
        logic [6:0] s;
        v   = int'(m_val[4*i +: 4]);
        msd = 0;
        for (int j = 0; j < D; j++)
            if (m_val[4*j +: 4] != 4'h0 || m_dot[j]) msd = j;
        s = (v >= 10 && !m_hex) ? 7'b0 : seg_tab[v];
        if (m_blz && i > msd) s = 7'b0;
        return {s, m_dot[i]};
    endfunction

    // Advance one clock edge and compute what the DUT should show after it
    task automatic step();
        int pre, idx;
        @(posedge clk);
        if (rst) begin
            k = 0; e_seg = 8'h00; e_com = 4'hF; e_tick = 1'b0;
            m_val = '0; m_dot = '0; m_hex = 1'b0; m_blz = 1'b0;
        end else begin
            pre    = k % S;
            idx    = (k / S) % D;
            e_seg  = m_decode(idx);
            e_com  = (pre == 0) ? 4'hF : ~(4'b0001 << idx);
            e_tick = (k == 0) || (k % (D*S) == D*S - 1);
            if (e_tick) begin
                m_val = bcd; m_dot = dot; m_hex = hex; m_blz = blz;
            end
            k++;
        end
        #1;
    endtask

    function automatic int active_digit(input logic [3:0] c);
        int a = -1;
        for (int j = 0; j < 4; j++) if (!c[j]) a = j;
        return a;
    endfunction

    task automatic test_reset();
        int nt = 0;
        rst = 1'b1; bcd = 16'h0; dot = 4'h0; hex = 1'b0; blz = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (seg !== 8'h00 || com !== 4'hF || tick !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_values c=%0d got seg=%h com=%b tick=%b exp seg=00 com=1111 tick=0", c, seg, com, tick);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (tick === 1'b1) nt++;
            n_tests++;
            if ({seg, com, tick} !== {e_seg, e_com, e_tick}) begin
                n_fail++;
                $display("FAIL reset_release k=%0d got seg=%b com=%b tick=%b exp seg=%b com=%b tick=%b", k, seg, com, tick, e_seg, e_com, e_tick);
            end
        end
        n_tests++;
        if (nt != 3) begin
            n_fail++;
            $display("FAIL reset_tick_count got %0d exp 3", nt);
        end
    endtask

    task automatic test_scan_order();
        logic [7:0] exp_slot [4];
        bit seen = 0;
        int a;
        exp_slot[0] = 8'b01100110; exp_slot[1] = 8'b11110010;
        exp_slot[2] = 8'b11011011; exp_slot[3] = 8'b01100000;
        bcd = 16'h1234; dot = 4'b0100; hex = 1'b0; blz = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            n_tests++;
            if ({seg, com, tick} !== {e_seg, e_com, e_tick}) begin
                n_fail++;
                $display("FAIL scan_model k=%0d got seg=%b com=%b tick=%b exp seg=%b com=%b tick=%b", k, seg, com, tick, e_seg, e_com, e_tick);
            end
            a = active_digit(com);
            if (seen && a >= 0) begin
                n_tests++;
                if (seg !== exp_slot[a]) begin
                    n_fail++;
                    $display("FAIL scan_digit%0d got %b exp %b", a, seg, exp_slot[a]);
                end
            end
            if (e_tick) seen = 1;
        end
    endtask

    task automatic test_hex();
        logic [7:0] exp_slot [4];
        bit seen;
        int a;
        exp_slot[0] = 8'b10001110; exp_slot[1] = 8'b10011100;
        exp_slot[2] = 8'b00111110; exp_slot[3] = 8'b11101110;
        bcd = 16'hABCF; dot = 4'h0; blz = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            hex  = (pass == 0);
            seen = 0;
            for (int c = 0; c < 36; c++) begin
                step();
                n_tests++;
                if ({seg, com, tick} !== {e_seg, e_com, e_tick}) begin
                    n_fail++;
                    $display("FAIL hex_model hex=%0d k=%0d got seg=%b com=%b tick=%b exp seg=%b com=%b tick=%b", hex, k, seg, com, tick, e_seg, e_com, e_tick);
                end
                a = active_digit(com);
                if (seen && a >= 0) begin
                    n_tests++;
                    if (seg !== (hex ? exp_slot[a] : 8'h00)) begin
                        n_fail++;
                        $display("FAIL hex_digit%0d hex=%0d got %b exp %b", a, hex, seg, hex ? exp_slot[a] : 8'h00);
                    end
                end
                if (e_tick) seen = 1;
            end
        end
    endtask

    task automatic test_lz();
        logic [15:0] pv [3];
        logic [3:0]  pd [3];
        logic [7:0]  ex [3][4];
        bit seen;
        int a;
        pv[0] = 16'h0042; pd[0] = 4'b0000;
        pv[1] = 16'h0000; pd[1] = 4'b0000;
        pv[2] = 16'h0042; pd[2] = 4'b0100;
        ex[0][0] = 8'b11011010; ex[0][1] = 8'b01100110; ex[0][2] = 8'h00;       ex[0][3] = 8'h00;
        ex[1][0] = 8'b11111100; ex[1][1] = 8'h00;       ex[1][2] = 8'h00;       ex[1][3] = 8'h00;
        ex[2][0] = 8'b11011010; ex[2][1] = 8'b01100110; ex[2][2] = 8'b11111101; ex[2][3] = 8'h00;
        hex = 1'b0; blz = 1'b1;
        for (int p = 0; p < 3; p++) begin
            bcd = pv[p]; dot = pd[p]; seen = 0;
            for (int c = 0; c < 36; c++) begin
                step();
                n_tests++;
                if ({seg, com, tick} !== {e_seg, e_com, e_tick}) begin
                    n_fail++;
                    $display("FAIL lz_model p=%0d k=%0d got seg=%b com=%b tick=%b exp seg=%b com=%b tick=%b", p, k, seg, com, tick, e_seg, e_com, e_tick);
                end
                a = active_digit(com);
                if (seen && a >= 0) begin
                    n_tests++;
                    if (seg !== ex[p][a]) begin
                        n_fail++;
                        $display("FAIL lz_digit%0d p=%0d got %b exp %b", a, p, seg, ex[p][a]);
                    end
                end
                if (e_tick) seen = 1;
            end
        end
        blz = 1'b0;
    endtask

    task automatic test_tearing();
        int phase = 0;
        int a;
        bcd = 16'h1111; dot = 4'h0; hex = 1'b0; blz = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (phase == 1 && (k % (D*S)) == 6) begin
                bcd   = 16'h2222;
                phase = 2;
            end
            step();
            n_tests++;
            if ({seg, com, tick} !== {e_seg, e_com, e_tick}) begin
                n_fail++;
                $display("FAIL tear_model k=%0d got seg=%b com=%b tick=%b exp seg=%b com=%b tick=%b", k, seg, com, tick, e_seg, e_com, e_tick);
            end
            a = active_digit(com);
            if (a >= 0 && (phase == 2 || phase == 3) && !e_tick) begin
                n_tests++;
                if (seg !== (phase == 2 ? 8'h60 : 8'hDA)) begin
                    n_fail++;
                    $display("FAIL tear_digit%0d phase=%0d got %h exp %h", a, phase, seg, phase == 2 ? 8'h60 : 8'hDA);
                end
            end
            if (e_tick && phase == 0) phase = 1;
            else if (e_tick && phase == 2) phase = 3;
        end
        n_tests++;
        if (phase != 3) begin
            n_fail++;
            $display("FAIL tear_progress got phase %0d exp 3", phase);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        bcd = 16'h5555; dot = 4'h0;
        while ((k % (D*S)) != 2*S + 2 && guard < 40) begin
            step();
            guard++;
        end
        n_tests++;
        if (guard >= 40) begin
            n_fail++;
            $display("FAIL rstmid_reach got guard=%0d exp <40", guard);
        end
        rst = 1'b1;
        bcd = 16'h9876;
        step();
        n_tests++;
        if (seg !== 8'h00 || com !== 4'hF || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_values got seg=%h com=%b tick=%b exp seg=00 com=1111 tick=0", seg, com, tick);
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            n_tests++;
            if ({seg, com, tick} !== {e_seg, e_com, e_tick}) begin
                n_fail++;
                $display("FAIL rstmid_model k=%0d got seg=%b com=%b tick=%b exp seg=%b com=%b tick=%b", k, seg, com, tick, e_seg, e_com, e_tick);
            end
            if (c == 0) begin
                n_tests++;
                if (tick !== 1'b1 || com !== 4'hF) begin
                    n_fail++;
                    $display("FAIL rstmid_first got tick=%b com=%b exp tick=1 com=1111", tick, com);
                end
            end
            if (c == 1) begin
                n_tests++;
                if (com !== 4'b1110 || seg !== 8'b10111110) begin
                    n_fail++;
                    $display("FAIL rstmid_digit0 got com=%b seg=%b exp com=1110 seg=10111110", com, seg);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(7) == 0) begin
                bcd = 16'($urandom);
                dot = 4'($urandom) & 4'($urandom);
                hex = 1'($urandom);
                blz = 1'($urandom);
                if ($urandom_range(2) == 0) bcd[15:8] = 8'h00;
            end
            step();
            n_tests++;
            if ({seg, com, tick} !== {e_seg, e_com, e_tick}) begin
                n_fail++;
                $display("FAIL random k=%0d got seg=%b com=%b tick=%b exp seg=%b com=%b tick=%b", k, seg, com, tick, e_seg, e_com, e_tick);
            end
        end
    endtask

    task automatic test_single_digit();
        logic [7:0] es;
        bcd1 = 4'h7; dot1 = 1'b1; rst1 = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (seg1 !== 8'h00 || com1 !== 1'b0 || tick1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_reset got seg=%h com=%b tick=%b exp seg=00 com=0 tick=0", seg1, com1, tick1);
        end
        rst1 = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            es = (c == 0) ? 8'hFC : 8'hE1;
            n_tests++;
            if (seg1 !== es || com1 !== (c % 3 != 0) || tick1 !== (c == 0 || c % 3 == 2)) begin
                n_fail++;
                $display("FAIL single_digit c=%0d got seg=%h com=%b tick=%b exp seg=%h com=%b tick=%b", c, seg1, com1, tick1, es, c % 3 != 0, c == 0 || c % 3 == 2);
            end
        end
    endtask

    initial begin
        seg_tab[0]  = 7'b1111110; seg_tab[1]  = 7'b0110000; seg_tab[2]  = 7'b1101101;
        seg_tab[3]  = 7'b1111001; seg_tab[4]  = 7'b0110011; seg_tab[5]  = 7'b1011011;
        seg_tab[6]  = 7'b1011111; seg_tab[7]  = 7'b1110000; seg_tab[8]  = 7'b1111111;
        seg_tab[9]  = 7'b1111011; seg_tab[10] = 7'b1110111; seg_tab[11] = 7'b0011111;
        seg_tab[12] = 7'b1001110; seg_tab[13] = 7'b0111101; seg_tab[14] = 7'b1001111;
        seg_tab[15] = 7'b1000111;
        rst1 = 1'b1; bcd1 = 4'h0; dot1 = 1'b0;
        k = 0;
        test_reset();
        test_scan_order();
        test_hex();
        test_lz();
        test_tearing();
        test_reset_mid();
        test_random();
        test_single_digit();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
